mem_bus_arbiter: RTL

- Shares the single downstream memory bus between the instruction-cache fill port (I) and the data-cache fill/writeback port (D).
- Uses round-robin arbitration, then sequences one transaction at a time: request, bus acknowledge, wait for done, return data.
- Requester-side handshake (req / reqack / addr / data / done) is identical to the cache-side handshake, so either cache connects unchanged.
- Sits between the caches and the top-level memory bus interface.

---
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle for mem_bus_arbiter: the I-cache fill port, the D-cache
// fill/writeback port and the downstream memory bus.
// modport slave  : the arbiter's view.
// modport master : the environment's view (caches plus memory bus).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
);
  // I-cache port (read only)
  logic              i_req;
  logic              i_reqack;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_done;
  // D-cache port
  logic              d_req;
  logic              d_reqack;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_done;
  // Downstream memory bus
  logic              bus_req;
  logic              bus_reqack;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [LINE_W-1:0] bus_wdata;
  logic [LINE_W-1:0] bus_rdata;
  logic              bus_done;
  // Watchdog error pulse
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata,
    input  bus_reqack, bus_rdata, bus_done,
    output i_reqack, i_rdata, i_done, d_reqack, d_rdata, d_done,
    output bus_req, bus_addr, bus_we, bus_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata,
    output bus_reqack, bus_rdata, bus_done,
    input  i_reqack, i_rdata, i_done, d_reqack, d_rdata, d_done,
    input  bus_req, bus_addr, bus_we, bus_wdata, err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory bus between the I-cache and
// the D-cache. Round-robin grant, then a single transaction is sequenced as
// request -> bus acknowledge -> wait for done -> return data.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles and pulses err.

// Alignment checker: requesters must present 64-byte aligned line addresses.
module mem_bus_arbiter_chk (
  input logic       clk,
  input logic       reset,
  input logic       i_req,
  input logic [5:0] i_addr_lo,
  input logic       d_req,
  input logic [5:0] d_addr_lo
);
  a_i_align: assert property (@(posedge clk) disable iff (reset)
    i_req |-> (i_addr_lo == 6'd0))
    else $fatal(1, "mem_bus_arbiter: i_addr not 64-byte aligned");

  a_d_align: assert property (@(posedge clk) disable iff (reset)
    d_req |-> (d_addr_lo == 6'd0))
    else $fatal(1, "mem_bus_arbiter: d_addr not 64-byte aligned");
endmodule

module mem_bus_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int LINE_W         = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS_REQ  = 2'd1,
    ST_BUS_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t            state_q;
  port_t             owner_q;
  port_t             last_grant_q;
  logic              i_reqack_q;
  logic              d_reqack_q;
  logic              i_done_q;
  logic              d_done_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              bus_req_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              bus_we_q;
  logic [LINE_W-1:0] bus_wdata_q;
  logic              err_q;

  logic              grant_vld_d;
  port_t             grant_port_d;
  logic              complete_d;
  logic              timeout_d;
  logic              finish_d;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0]       timeout_cnt_q;

  // Watchdog fires when the cycle after the last counted one would reach the limit.
  assign timeout_d = (state_q != ST_IDLE) &&
                     (timeout_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic              unused_timeout_s;

  assign timeout_d        = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
`endif

  // Round-robin pick: a tie goes to the port that did not win last time.
  always_comb begin
    grant_vld_d = bus.i_req | bus.d_req;
    if (bus.i_req && bus.d_req) begin
      grant_port_d = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
    end else if (bus.d_req) begin
      grant_port_d = PORT_D;
    end else begin
      grant_port_d = PORT_I;
    end
  end

  // Completion: done in BUS_WAIT, or ack and done landing together in BUS_REQ.
  assign complete_d = ((state_q == ST_BUS_WAIT) && bus.bus_done) ||
                      ((state_q == ST_BUS_REQ) && bus.bus_reqack && bus.bus_done);
  assign finish_d   = complete_d | timeout_d;

  // Arbitration/sequencing FSM; every output is driven from a register here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= PORT_I;
      last_grant_q  <= PORT_D;
      i_reqack_q    <= 1'b0;
      d_reqack_q    <= 1'b0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      bus_req_q     <= 1'b0;
      bus_addr_q    <= '0;
      bus_we_q      <= 1'b0;
      bus_wdata_q   <= '0;
      err_q         <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_cnt_q <= 16'd0;
`endif
    end else begin
      i_reqack_q <= 1'b0;
      d_reqack_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            owner_q      <= grant_port_d;
            last_grant_q <= grant_port_d;
            i_reqack_q   <= (grant_port_d == PORT_I);
            d_reqack_q   <= (grant_port_d == PORT_D);
            bus_req_q    <= 1'b1;
            bus_addr_q   <= (grant_port_d == PORT_D) ? bus.d_addr : bus.i_addr;
            bus_we_q     <= (grant_port_d == PORT_D) & bus.d_we;
            bus_wdata_q  <= (grant_port_d == PORT_D) ? bus.d_wdata : '0;
            state_q      <= ST_BUS_REQ;
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_cnt_q <= 16'd0;
`endif
          end
        end
        ST_BUS_REQ, ST_BUS_WAIT: begin
          if (finish_d) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_IDLE;
            err_q     <= timeout_d & ~complete_d;
            if (owner_q == PORT_D) begin
              d_done_q <= 1'b1;
              if (complete_d && !bus_we_q) begin
                d_rdata_q <= bus.bus_rdata;
              end
            end else begin
              i_done_q <= 1'b1;
              if (complete_d) begin
                i_rdata_q <= bus.bus_rdata;
              end
            end
          end else if ((state_q == ST_BUS_REQ) && bus.bus_reqack) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_BUS_WAIT;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          timeout_cnt_q <= timeout_cnt_q + 16'd1;
`endif
        end
        default: begin
          state_q   <= ST_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_reqack  = i_reqack_q;
  assign bus.d_reqack  = d_reqack_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.err       = err_q;

  mem_bus_arbiter_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .i_req     (bus.i_req),
    .i_addr_lo (bus.i_addr[5:0]),
    .d_req     (bus.d_req),
    .d_addr_lo (bus.d_addr[5:0])
  );

endmodule
